// File: rtl/usequencer.sv
// Microprogram sequencer: next microstore address selection, subroutine return
// stack and a MOC wait watchdog that forces a jump to the abort routine.
module usequencer #(
    parameter int             AW         = 7,
    parameter int             DEPTH      = 4,
    parameter int             TIMEOUT    = 15,
    parameter logic [AW-1:0]  ABORT_ADDR = 7'd90
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic [2:0]              ns,
    input  logic [AW-1:0]           cr_addr,
    input  logic                    inv,
    input  logic                    cond,
    input  logic [AW-1:0]           dec_addr,
    input  logic                    dec_valid,
    input  logic                    moc,
    output logic [AW-1:0]           index,
    output logic                    moc_wait,
    output logic                    abort,
    output logic                    stk_err,
    output logic [$clog2(DEPTH):0]  sp
);

    localparam int SPW = $clog2(DEPTH) + 1;
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        NS_INC     = 3'b000,
        NS_JUMP    = 3'b001,
        NS_DECODE  = 3'b010,
        NS_COND    = 3'b011,
        NS_WAITMOC = 3'b100,
        NS_CALL    = 3'b101,
        NS_RET     = 3'b110,
        NS_FETCH   = 3'b111
    } ns_t;

    ns_t              ns_sel;
    logic [AW-1:0]    upc_reg, upc_next, upc_inc;
    logic [SPW-1:0]   sp_reg, sp_next, sp_dec;
    logic [TW-1:0]    timer_reg, timer_next;
    logic             abort_reg, abort_next;
    logic             err_reg, err_next;
    logic             push;
    logic [AW-1:0]    stack [DEPTH];

    assign ns_sel  = ns_t'(ns);
    assign upc_inc = upc_reg + AW'(1);
    assign sp_dec  = sp_reg - SPW'(1);

    always_comb begin
        upc_next   = upc_reg;
        sp_next    = sp_reg;
        timer_next = timer_reg;
        abort_next = 1'b0;
        err_next   = err_reg;
        push       = 1'b0;
        if (en) begin
            // any cycle outside WAITMOC restarts the watchdog from zero
            timer_next = '0;
            case (ns_sel)
                NS_INC:    upc_next = upc_inc;
                NS_JUMP:   upc_next = cr_addr;
                NS_DECODE: upc_next = dec_valid ? dec_addr : upc_reg;
                NS_COND:   upc_next = (cond ^ inv) ? cr_addr : upc_inc;
                NS_WAITMOC: begin
                    if (moc) begin
                        upc_next = upc_inc;
                    end else if (timer_reg < TW'(TIMEOUT - 1)) begin
                        timer_next = timer_reg + TW'(1);
                    end else begin
                        upc_next   = ABORT_ADDR;
                        abort_next = 1'b1;
                    end
                end
                NS_CALL: begin
                    if (sp_reg < SPW'(DEPTH)) begin
                        push     = 1'b1;
                        sp_next  = sp_reg + SPW'(1);
                        upc_next = cr_addr;
                    end else begin
                        err_next = 1'b1;
                        upc_next = ABORT_ADDR;
                    end
                end
                NS_RET: begin
                    if (sp_reg != '0) begin
                        upc_next = stack[sp_dec[SPW-2:0]];
                        sp_next  = sp_dec;
                    end else begin
                        err_next = 1'b1;
                        upc_next = '0;
                    end
                end
                NS_FETCH:  upc_next = '0;
                default:   upc_next = upc_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            upc_reg   <= '0;
            sp_reg    <= '0;
            timer_reg <= '0;
            abort_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            upc_reg   <= upc_next;
            sp_reg    <= sp_next;
            timer_reg <= timer_next;
            abort_reg <= abort_next;
            err_reg   <= err_next;
        end
    end

    // stack contents are don't-care after reset, so no reset is applied
    always_ff @(posedge clk) begin
        if (push) begin
            stack[sp_reg[SPW-2:0]] <= upc_inc;
        end
    end

    assign index    = upc_reg;
    assign sp       = sp_reg;
    assign abort    = abort_reg;
    assign stk_err  = err_reg;
    assign moc_wait = (ns == 3'b100) & ~moc & en;

endmodule

// File: tb/tb_usequencer.sv
// Directed bench for usequencer: sequencing modes, MOC watchdog, return stack,
// enable freeze and asynchronous reset.
module tb_usequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic [2:0] ns;
    logic [6:0] cr_addr;
    logic       inv;
    logic       cond;
    logic [6:0] dec_addr;
    logic       dec_valid;
    logic       moc;
    logic [6:0] index;
    logic       moc_wait;
    logic       abort;
    logic       stk_err;
    logic [2:0] sp;

    int checks = 0;
    int errors = 0;

    usequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .ns        (ns),
        .cr_addr   (cr_addr),
        .inv       (inv),
        .cond      (cond),
        .dec_addr  (dec_addr),
        .dec_valid (dec_valid),
        .moc       (moc),
        .index     (index),
        .moc_wait  (moc_wait),
        .abort     (abort),
        .stk_err   (stk_err),
        .sp        (sp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic jump(input logic [6:0] a);
        ns = 3'b001; cr_addr = a; tick(1);
        check("jump", 32'(index), 32'(a));
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b1; ns = 3'b000; cr_addr = '0; inv = 1'b0;
        cond = 1'b0; dec_addr = '0; dec_valid = 1'b0; moc = 1'b0;

        #12;
        check("rst_index", 32'(index), 0);
        check("rst_sp", 32'(sp), 0);
        check("rst_abort", 32'(abort), 0);
        check("rst_stk_err", 32'(stk_err), 0);
        #10 reset_n = 1'b1;
        check("rel_index", 32'(index), 0);

        // INC with wrap 127 -> 0
        for (int i = 1; i <= 130; i++) begin
            tick(1);
            check("inc", 32'(index), 32'(i % 128));
        end
        check("inc_abort", 32'(abort), 0);
        check("inc_stk_err", 32'(stk_err), 0);

        // DECODE stall then dispatch
        ns = 3'b010; dec_addr = 7'h28; dec_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("dec_stall", 32'(index), 2);
        end
        dec_valid = 1'b1; tick(1);
        check("dec_go", 32'(index), 32'h28);
        dec_valid = 1'b0;

        // COND
        jump(7'd5);
        ns = 3'b011; cr_addr = 7'h40; cond = 1'b1; inv = 1'b0; tick(1);
        check("cond_taken", 32'(index), 32'h40);
        jump(7'd5);
        ns = 3'b011; cr_addr = 7'h40; cond = 1'b1; inv = 1'b1; tick(1);
        check("cond_inv_fall", 32'(index), 6);
        cond = 1'b0; inv = 1'b1; tick(1);
        check("cond_inv_taken", 32'(index), 32'h40);
        inv = 1'b0;

        // MOC arrives on 4th cycle
        jump(7'h30);
        ns = 3'b100; moc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("mw_high", 32'(moc_wait), 1);
            tick(1);
            check("mw_hold", 32'(index), 32'h30);
        end
        moc = 1'b1;
        #1 check("mw_low", 32'(moc_wait), 0);
        tick(1);
        check("moc_done", 32'(index), 32'h31);

        // timeout after exactly 15 cycles, then restart from 0
        moc = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            check("to_wait_abort", 32'(abort), 0);
        end
        check("to_wait_index", 32'(index), 32'h31);
        tick(1);
        check("to_index", 32'(index), 90);
        check("to_abort", 32'(abort), 1);
        for (int i = 0; i < 14; i++) begin
            tick(1);
            check("to2_wait_abort", 32'(abort), 0);
        end
        tick(1);
        check("to2_abort", 32'(abort), 1);
        check("to2_index", 32'(index), 90);

        // moc on timeout cycle wins
        for (int i = 0; i < 14; i++) tick(1);
        check("race_pre_abort", 32'(abort), 0);
        moc = 1'b1; tick(1);
        check("race_index", 32'(index), 91);
        check("race_abort", 32'(abort), 0);
        moc = 1'b0;

        // stack: 4 calls push 11,21,31,41
        jump(7'd10);
        ns = 3'b101;
        cr_addr = 7'd20; tick(1);
        cr_addr = 7'd30; tick(1);
        cr_addr = 7'd40; tick(1);
        cr_addr = 7'd50; tick(1);
        check("call4_index", 32'(index), 50);
        check("call4_sp", 32'(sp), 4);
        check("call4_err", 32'(stk_err), 0);
        cr_addr = 7'd60; tick(1);
        check("ovf_index", 32'(index), 90);
        check("ovf_sp", 32'(sp), 4);
        check("ovf_err", 32'(stk_err), 1);
        ns = 3'b110;
        tick(1); check("ret1", 32'(index), 41); check("ret1_sp", 32'(sp), 3);
        tick(1); check("ret2", 32'(index), 31);
        tick(1); check("ret3", 32'(index), 21);
        tick(1); check("ret4", 32'(index), 11); check("ret4_sp", 32'(sp), 0);
        tick(1);
        check("udf_index", 32'(index), 0);
        check("udf_sp", 32'(sp), 0);
        check("udf_err", 32'(stk_err), 1);

        // en=0 freezes a WAITMOC
        jump(7'h50);
        ns = 3'b100; moc = 1'b0; en = 1'b0;
        #1 check("frz_mw", 32'(moc_wait), 0);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("frz_abort", 32'(abort), 0);
        end
        check("frz_index", 32'(index), 32'h50);
        en = 1'b1;
        for (int i = 0; i < 14; i++) tick(1);
        check("frz_timer_abort", 32'(abort), 0);
        tick(1);
        check("frz_timer_to", 32'(abort), 1);

        // asynchronous reset between edges
        ns = 3'b101; cr_addr = 7'd20; tick(1);
        check("pre_rst_sp", 32'(sp), 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_index", 32'(index), 0);
        check("arst_sp", 32'(sp), 0);
        check("arst_err", 32'(stk_err), 0);
        check("arst_abort", 32'(abort), 0);
        #3 reset_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usequencer.md
# usequencer

Microprogram sequencer for the control unit. Each cycle it computes the next microstore address from the next-state field of the current microinstruction. Inputs it uses are the instruction decoder address, the condition tester result and the memory-operation-complete (MOC) handshake. It holds the microprogram counter that drives the microstore ROM index, a small subroutine return stack and an MOC timeout watchdog.

## Interface
- AW, 7: microstore address width; 128 microinstructions.
- DEPTH, 4: return-stack entries.
- TIMEOUT, 15: maximum consecutive cycles allowed in a MOC wait before abort.
- ABORT_ADDR, 7'd90: microstore entry entered on MOC timeout or stack error.
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  advance enable; low freezes all state, including the timeout counter.
- ns  in  3  next-state select field of the current microinstruction.
- cr_addr  in  AW  branch/call target field of the current microinstruction.
- inv  in  1  invert the condition for conditional branches.
- cond  in  1  condition tester result.
- dec_addr  in  AW  microroutine entry address from the instruction decoder.
- dec_valid  in  1  dec_addr is valid this cycle.
- moc  in  1  memory operation complete.
- index  out  AW  microstore ROM address; registered.
- moc_wait  out  1  high while a WAITMOC microinstruction is holding.
- abort  out  1  one-cycle pulse on MOC timeout.
- stk_err  out  1  sticky stack overflow/underflow flag; cleared only by reset.
- sp  out  $clog2(DEPTH)+1  current return-stack occupancy, 0..DEPTH.

## Operation
- Register upc drives index directly. The ROM is combinational, so ns, cr_addr and inv describe the microinstruction at the current index.
- When en=1, the next upc is chosen by ns as follows:
  - 000 INC: upc+1, modulo 2^AW (127 → 0).
  - 001 JUMP: cr_addr.
  - 010 DECODE: dec_addr if dec_valid, otherwise hold upc (stall).
  - 011 COND: cr_addr if (cond ^ inv), otherwise upc+1.
  - 100 WAITMOC:
    - moc=1: upc+1 and clear the timer.
    - moc=0 and timer < TIMEOUT-1: hold upc and increment the timer.
    - moc=0 and timer = TIMEOUT-1: go to ABORT_ADDR, pulse abort for one cycle and clear the timer.
  - 101 CALL:
    - sp < DEPTH: push upc+1, sp+1, then go to cr_addr.
    - sp = DEPTH: no push, set stk_err, go to ABORT_ADDR.
  - 110 RET:
    - sp > 0: pop into upc, sp-1.
    - sp = 0: set stk_err, go to 0.
  - 111 FETCH: go to 0 (start of instruction fetch). The stack is not cleared.
- moc_wait = (ns==100) & ~moc & en, combinational.
- The timer is cleared on every cycle where ns≠100, so each WAITMOC episode starts from 0.
- The stack is LIFO and the push address is upc+1 with wrap. Entries above sp are don't-care.
- When en=0, upc, sp, stack and timer are frozen, abort=0, and stk_err holds.

## Timing
- On reset assertion (asynchronous, mid-operation included):
  - index=0, sp=0, timer=0, abort=0, stk_err=0.
  - Stack contents are don't-care.
- First microinstruction after reset release: entry 0, on the first clk edge that samples reset_n=1.
- Latency: one cycle from ns/cond/moc/dec_addr sample to new index.
- abort is registered and asserts in the same cycle index becomes ABORT_ADDR.
- MOC handshake:
  - moc is sampled only while ns=100.
  - moc high on the first WAITMOC cycle gives zero wait states.
  - An abort occurs after exactly TIMEOUT consecutive cycles of moc=0 with en=1.
- Simultaneous events:
  - moc=1 on the timeout cycle: moc wins, giving upc+1 with no abort.
  - CALL with sp=DEPTH: error path wins; nothing is pushed.

## Test plan
- Reset and INC: release reset with ns=000, run 130 cycles → index goes 0,1,…,127,0,1; all flags 0.
- DECODE stall: ns=010, dec_valid=0 for 3 cycles then dec_addr=0x28, dec_valid=1 → index holds 3 cycles, then 0x28 next cycle.
- COND: index=5, ns=011, cr_addr=0x40; cond=1,inv=0 → 0x40; cond=1,inv=1 → 6.
- MOC: ns=100 with moc high on the 4th cycle → moc_wait high 3 cycles, then index+1. With moc never high → index=90 after exactly 15 cycles, abort pulse 1 cycle, timer restarts from 0.
- Stack:
  - CALL ×4 from index 10 with cr_addr=20 → sp=4.
  - A 5th CALL → index=90, stk_err=1, sp stays 4.
  - RET ×4 returns to pushed addresses in reverse order.
  - A 5th RET → index=0, stk_err stays 1.
- en and reset mid-op: hold en=0 during WAITMOC for 20 cycles → no abort, index frozen. Assert reset_n low between edges → index=0, sp=0, stk_err=0 immediately.
